// File: rtl/sram_ctrl_if.sv
// Core-side request/response bus for sram_ctrl.
// Ports (signals):
//   req   - single-cycle request strobe, taken only while busy=0
//   wr    - 1=write, 0=read, sampled with req
//   size  - 0=byte, 1=halfword, 2=word, 3=illegal
//   addr  - 19-bit byte address
//   wdata - little-endian write data
//   rdata - read data, updated only on a successful read's ready
//   ready - one-cycle completion pulse
//   err   - one-cycle pulse alongside ready for a rejected request
//   busy  - high from the cycle after acceptance through the ready cycle
// Modports: master = core side, slave = controller side.
interface sram_ctrl_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [18:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        err;
   logic        busy;

   modport master (output req, wr, size, addr, wdata,
                   input  rdata, ready, err, busy);
   modport slave  (input  req, wr, size, addr, wdata,
                   output rdata, ready, err, busy);
endinterface

// File: rtl/sram_ctrl.sv
// Sequencer for an external 8-bit asynchronous SRAM. Each byte, halfword or
// word request is split into per-byte SRAM cycles (little-endian, byte k at
// addr+k). Read and write-enable wait states come from parameters.
// Ports:
//   clk            - clock, all state changes on the rising edge
//   rstn           - synchronous active-low reset
//   bus            - core-side request/response bus (sram_ctrl_if.slave)
//   sram_ce_bar    - chip enable, active-low
//   sram_oe_bar    - output enable, active-low
//   sram_we_bar    - write enable, active-low
//   sram_data_dir  - `IOR_DIR_OUT while write data is driven, else input
//   sram_data_out  - write byte to the pad
//   sram_data_in   - read byte from the pad
//   sram_addr      - SRAM byte address
// Every output is a register loaded with the value belonging to the state
// being entered, so outputs line up exactly with the state they describe.
`ifndef IOR_DIR_OUT
`define IOR_DIR_OUT 1'b1
`endif

module sram_ctrl #(
   parameter int WAIT_CYCLES = 1,
   parameter int WE_CYCLES   = 1
) (
   input  logic        clk,
   input  logic        rstn,
   sram_ctrl_if.slave  bus,
   output logic        sram_ce_bar,
   output logic        sram_oe_bar,
   output logic        sram_we_bar,
   output logic        sram_data_dir,
   output logic [7:0]  sram_data_out,
   input  logic [7:0]  sram_data_in,
   output logic [18:0] sram_addr
);
   localparam logic       DIR_OUT   = `IOR_DIR_OUT;
   localparam logic       DIR_IN    = ~DIR_OUT;
   localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);
   localparam logic [7:0] WE_LAST   = 8'(WE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      SETUP  = 3'd2,
      ACCESS = 3'd3,
      WHOLD  = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t      state_r, state_nxt_s;
   logic        wr_r, wr_nxt_s;
   logic [1:0]  size_r, size_nxt_s;
   logic [18:0] addr_r, addr_nxt_s;
   logic [31:0] wdata_r, wdata_nxt_s;
   logic [1:0]  k_r, k_nxt_s;
   logic [1:0]  klast_r, klast_nxt_s;   // index of the last byte (nbytes-1)
   logic [7:0]  cnt_r, cnt_nxt_s;
   logic [31:0] shadow_r, shadow_nxt_s;
   logic        ce_r, ce_nxt_s;
   logic        oe_r, oe_nxt_s;
   logic        we_r, we_nxt_s;
   logic        dir_r, dir_nxt_s;
   logic [7:0]  dout_r, dout_nxt_s;
   logic [18:0] saddr_r, saddr_nxt_s;
   logic [31:0] rdata_r, rdata_nxt_s;
   logic        ready_r, ready_nxt_s;
   logic        err_r, err_nxt_s;
   logic        busy_r, busy_nxt_s;
   logic        byte_done_s;
   logic        misalign_s;

   assign misalign_s = (size_r == 2'd3) ||
                       ((size_r == 2'd1) && addr_r[0]) ||
                       ((size_r == 2'd2) && (addr_r[1:0] != 2'b00));

   // Next-state, datapath and next-output computation.
   always_comb begin
      state_nxt_s  = state_r;
      wr_nxt_s     = wr_r;
      size_nxt_s   = size_r;
      addr_nxt_s   = addr_r;
      wdata_nxt_s  = wdata_r;
      k_nxt_s      = k_r;
      klast_nxt_s  = klast_r;
      cnt_nxt_s    = cnt_r;
      shadow_nxt_s = shadow_r;
      ce_nxt_s     = 1'b1;
      oe_nxt_s     = 1'b1;
      we_nxt_s     = 1'b1;
      dir_nxt_s    = DIR_IN;
      dout_nxt_s   = dout_r;
      saddr_nxt_s  = saddr_r;
      rdata_nxt_s  = rdata_r;
      ready_nxt_s  = 1'b0;
      err_nxt_s    = 1'b0;
      byte_done_s  = 1'b0;

      case (state_r)
         IDLE: begin
            if (bus.req) begin
               wr_nxt_s     = bus.wr;
               size_nxt_s   = bus.size;
               addr_nxt_s   = bus.addr;
               wdata_nxt_s  = bus.wdata;
               k_nxt_s      = 2'd0;
               shadow_nxt_s = 32'd0;   // unread upper bytes stay zero
               state_nxt_s  = CHECK;
            end else begin
               state_nxt_s  = IDLE;
            end
         end
         CHECK: begin
            if (misalign_s) begin
               ready_nxt_s = 1'b1;
               err_nxt_s   = 1'b1;
               state_nxt_s = DONE;
            end else begin
               case (size_r)
                  2'd0:    klast_nxt_s = 2'd0;
                  2'd1:    klast_nxt_s = 2'd1;
                  default: klast_nxt_s = 2'd3;
               endcase
               state_nxt_s = SETUP;
            end
         end
         SETUP: begin
            cnt_nxt_s   = 8'd0;
            state_nxt_s = ACCESS;
         end
         ACCESS: begin
            if (!wr_r) begin
               if (cnt_r == WAIT_LAST) begin
                  shadow_nxt_s[{k_r, 3'b000} +: 8] = sram_data_in;
                  byte_done_s = 1'b1;
               end else begin
                  cnt_nxt_s = cnt_r + 8'd1;
               end
            end else begin
               if (cnt_r == WE_LAST) begin
                  state_nxt_s = WHOLD;
               end else begin
                  cnt_nxt_s = cnt_r + 8'd1;
               end
            end
         end
         WHOLD: begin
            byte_done_s = 1'b1;
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase

      if (byte_done_s) begin
         if (k_r != klast_r) begin
            k_nxt_s     = k_r + 2'd1;
            state_nxt_s = SETUP;
         end else begin
            ready_nxt_s = 1'b1;
            state_nxt_s = DONE;
            if (!wr_r) begin
               rdata_nxt_s = shadow_nxt_s;
            end else begin
               rdata_nxt_s = rdata_r;
            end
         end
      end else begin
         k_nxt_s = k_nxt_s;
      end

      // Strobe levels belong to the state being entered. ce_bar (and oe_bar
      // for reads) stays low from one byte's SETUP through the next.
      case (state_nxt_s)
         SETUP: begin
            ce_nxt_s    = 1'b0;
            saddr_nxt_s = addr_r + {17'd0, k_nxt_s};
            if (!wr_r) begin
               oe_nxt_s = 1'b0;
            end else begin
               dir_nxt_s  = DIR_OUT;
               dout_nxt_s = wdata_r[{k_nxt_s, 3'b000} +: 8];
            end
         end
         ACCESS: begin
            ce_nxt_s = 1'b0;
            if (!wr_r) begin
               oe_nxt_s = 1'b0;
            end else begin
               dir_nxt_s = DIR_OUT;
               we_nxt_s  = 1'b0;
            end
         end
         WHOLD: begin
            ce_nxt_s  = 1'b0;
            dir_nxt_s = DIR_OUT;
         end
         default: begin
            ce_nxt_s = 1'b1;
         end
      endcase

      busy_nxt_s = (state_nxt_s != IDLE);
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r  <= IDLE;
         wr_r     <= 1'b0;
         size_r   <= 2'd0;
         addr_r   <= 19'd0;
         wdata_r  <= 32'd0;
         k_r      <= 2'd0;
         klast_r  <= 2'd0;
         cnt_r    <= 8'd0;
         shadow_r <= 32'd0;
         ce_r     <= 1'b1;
         oe_r     <= 1'b1;
         we_r     <= 1'b1;
         dir_r    <= DIR_IN;
         dout_r   <= 8'd0;
         saddr_r  <= 19'd0;
         rdata_r  <= 32'd0;
         ready_r  <= 1'b0;
         err_r    <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         wr_r     <= wr_nxt_s;
         size_r   <= size_nxt_s;
         addr_r   <= addr_nxt_s;
         wdata_r  <= wdata_nxt_s;
         k_r      <= k_nxt_s;
         klast_r  <= klast_nxt_s;
         cnt_r    <= cnt_nxt_s;
         shadow_r <= shadow_nxt_s;
         ce_r     <= ce_nxt_s;
         oe_r     <= oe_nxt_s;
         we_r     <= we_nxt_s;
         dir_r    <= dir_nxt_s;
         dout_r   <= dout_nxt_s;
         saddr_r  <= saddr_nxt_s;
         rdata_r  <= rdata_nxt_s;
         ready_r  <= ready_nxt_s;
         err_r    <= err_nxt_s;
         busy_r   <= busy_nxt_s;
      end
   end

   assign sram_ce_bar   = ce_r;
   assign sram_oe_bar   = oe_r;
   assign sram_we_bar   = we_r;
   assign sram_data_dir = dir_r;
   assign sram_data_out = dout_r;
   assign sram_addr     = saddr_r;
   assign bus.rdata     = rdata_r;
   assign bus.ready     = ready_r;
   assign bus.err       = err_r;
   assign bus.busy      = busy_r;
endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Sequencer for the external 8-bit asynchronous SRAM. It accepts byte, halfword and word requests from the core-side bus and breaks each one into per-byte SRAM read or write cycles. It drives the SRAM strobe, address and data-direction signals that the I/O ring forwards to the pads. Wait states are set by parameters, so one RTL serves SRAM parts of different speeds.

## Interface
- WAIT_CYCLES, 1, read access cycles per byte (≥1)
- WE_CYCLES, 1, write-enable low cycles per byte (≥1)

- clk  in  1  clock; all state changes on rising edge
- rstn  in  1  synchronous reset, active-low
- req  in  1  single-cycle request strobe; accepted only when busy=0
- wr  in  1  1=write, 0=read; sampled with req
- size  in  2  0=byte, 1=halfword, 2=word, 3=illegal; sampled with req
- addr  in  19  byte address; sampled with req
- wdata  in  32  write data, little-endian; sampled with req
- rdata  out  32  read data; updates only with a successful read's ready
- ready  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with ready for a rejected request
- busy  out  1  high from cycle after acceptance through the ready cycle
- sram_ce_bar, sram_oe_bar, sram_we_bar  out  1 each  SRAM strobes, active-low
- sram_data_dir  out  1  `IOR_DIR_OUT while driving write data, otherwise input
- sram_data_out  out  8  write byte
- sram_data_in  in  8  read byte from pad
- sram_addr  out  19  SRAM byte address

## Operation
- **Registered outputs.** All outputs are registered. Reset values: ce/oe/we_bar=1, sram_data_dir=input, sram_data_out=0, sram_addr=0, rdata=0, ready=0, err=0, busy=0.
- **States:** IDLE, CHECK, SETUP, ACCESS, WHOLD, DONE.
- **IDLE.** If req=1, capture wr/size/addr/wdata, clear byte index k and go to CHECK. Otherwise stay in IDLE.
- **CHECK.** Reject with err if:
  - size=3, or
  - size=1 and addr[0]=1, or
  - size=2 and addr[1:0]≠0.
  - On reject: go to DONE with err set. No SRAM strobe moves.
  - Otherwise set nbytes = 1/2/4 and go to SETUP.
- **SETUP** (1 cycle): sram_addr = addr+k and ce_bar=0.
  - Read: oe_bar=0 and dir=input.
  - Write: dir=`IOR_DIR_OUT, sram_data_out = wdata[8k+7:8k], we_bar=1.
- **ACCESS.**
  - Read: stay WAIT_CYCLES cycles. On the last cycle, capture sram_data_in into shadow byte k.
  - Write: stay WE_CYCLES cycles with we_bar=0, then go to WHOLD.
- **WHOLD** (writes only, 1 cycle): we_bar=1; address and data stay driven.
- **After each byte:** if k<nbytes−1, increment k and go to SETUP. Otherwise go to DONE.
- **Strobes across bytes.** ce_bar stays low between bytes of one request. For reads, oe_bar also stays low.
- **DONE** (1 cycle):
  - ce/oe/we_bar=1, dir=input, ready=1, busy still 1.
  - On a successful read, rdata = shadow, with bytes above nbytes zero-filled.
  - Writes and errors leave rdata unchanged.
  - Next state is IDLE.
- **Byte order.** Little-endian: byte k sits at addr+k and maps to bits [8k+7:8k].
- **Address range.** Aligned accesses never wrap past 0x7FFFF; no wrap logic.
- **req while busy=1:** ignored and dropped, including a req in the DONE cycle.
- **rstn=0 at any time:** next cycle all outputs take reset values and the state is IDLE. An in-flight access is abandoned with no ready pulse.

## Timing
- Request accepted at cycle T. CHECK runs at T+1; SETUP of byte 0 starts at T+2.
- Read, per byte: 1+WAIT_CYCLES cycles.
- Write, per byte: 2+WE_CYCLES cycles.
- ready cycle = T+2 + nbytes·(per-byte cycles).
  - Byte read, WAIT=1: ready at T+4.
  - Word read, WAIT=1: ready at T+10.
  - Byte write, WE=1: ready at T+5.
  - Word write, WE=1: ready at T+14.
  - Rejected request: ready=err=1 at T+2.
- Earliest next accept is the cycle after ready (IDLE).
- Write data is stable on sram_data_out for ≥1 cycle before the we_bar falling edge and ≥1 cycle after its rising edge.

## Test plan
- Reset: hold rstn=0 for 3 cycles → ce/oe/we_bar=1, dir=input, ready=err=busy=0, rdata=0.
- Word write then read-back (WAIT=WE=1): write 0xA1B2C3D4 to 0x00100, with an SRAM model attached.
  - Model bytes at 0x100..0x103 = D4,C3,B2,A1.
  - ready at T+14.
  - Read back: rdata=0xA1B2C3D4, ready at T+10.
- Halfword read at 0x7FFFE with model bytes 0x34,0x12 → rdata=0x00001234. sram_addr shows 0x7FFFE then 0x7FFFF; no wrap.
- Misaligned requests:
  - word at 0x00002 → err=ready=1 at T+2, no SRAM strobe activity, rdata unchanged.
  - size=3 → same response.
- Busy and reset abort:
  - Strobe req during a word read → second request dropped, exactly one ready pulse.
  - rstn=0 mid-write after byte 1 → next cycle strobes high, busy=0, no ready; model shows only byte 0 written.
- WAIT_CYCLES=3, WE_CYCLES=2:
  - Byte read → ready at T+6; oe_bar low for 4 cycles.
  - Byte write → we_bar low for exactly 2 cycles, ready at T+6.
